shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier; the arithmetic complement of the team's restoring divider, for the same ALU datapath.
- Computes an N x N -> 2N product, one multiplier bit per clock, using the team's RCA ripple-carry adder at 2N width for accumulation.
- A start/busy/done handshake lets the control unit launch a multiply, then read the product.

---
 rtl/shift_add_multiplier.sv | 123 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 128 ++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier with a start/busy/done handshake.
// Optional macro SHIFT_ADD_MULT_EARLY_DONE_EN ends RUN once the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   mcand_sh_q, mcand_sh_d;
  logic [N-1:0]     mplr_sh_q, mplr_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [2*N-1:0]   add_sum;
  logic             add_cout;
  logic             last_step;

  // Ripple-carry adder, bit by bit, carry-in fixed at 0.
  function automatic logic [2*N:0] rca_add(input logic [2*N-1:0] a, input logic [2*N-1:0] b);
    logic [2*N-1:0] s;
    logic           c;
    c = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  assign {add_cout, add_sum} = rca_add(acc_q, mcand_sh_q);

`ifdef SHIFT_ADD_MULT_EARLY_DONE_EN
  assign last_step = (cnt_q == CW'(N - 1)) || ((mplr_sh_q >> 1) == '0);
`else
  assign last_step = (cnt_q == CW'(N - 1));
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_sh_d = mcand_sh_q;
    mplr_sh_d  = mplr_sh_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    done       = 1'b0;
    product    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = '0;
          mcand_sh_d = {{N{1'b0}}, multiplicand};
          mplr_sh_d  = multiplier;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (mplr_sh_q[0]) acc_d = add_sum;
        mcand_sh_d = mcand_sh_q << 1;
        mplr_sh_d  = mplr_sh_q >> 1;
        cnt_d      = cnt_q + 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        product = acc_q;
        if (start) begin
          acc_d      = '0;
          mcand_sh_d = {{N{1'b0}}, multiplicand};
          mplr_sh_d  = multiplier;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean IDLE.
        state_d    = IDLE;
        acc_d      = '0;
        mcand_sh_d = '0;
        mplr_sh_d  = '0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_sh_q <= '0;
      mplr_sh_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_sh_q <= mcand_sh_d;
      mplr_sh_q  <= mplr_sh_d;
      cnt_q      <= cnt_d;
`ifndef SYNTHESIS
      if (state_q == RUN && mplr_sh_q[0]) assert (!add_cout);
`endif
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier (N=4) against an arithmetic reference model.
module tb_shift_add_multiplier;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int checkCount = 0;
  int passCount  = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference model: number of RUN cycles the multiply of b should take.
  function automatic int expLatency(input int b);
`ifdef SHIFT_ADD_MULT_EARLY_DONE_EN
    int hi;
    hi = 0;
    for (int i = 0; i < N; i++) if ((b >> i) & 1) hi = i + 1;
    return (hi < 1) ? 1 : hi;
`else
    return N;
`endif
  endfunction

  // Launch a multiply, optionally disturbing inputs during RUN, and check the result.
  task automatic applyStimulus(input int a, input int b, input bit perturb);
    int runCycles;
    int expProd;
    expProd = a * b;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = N'(a);
    multiplier   = N'(b);
    @(negedge clk);
    start     = 1'b0;
    runCycles = 0;
    while (busy === 1'b1 && runCycles < 50) begin
      checkOutput("run_done_product", {done, product}, '0);
      if (perturb) begin
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        start        = 1'($urandom_range(0, 1));
      end
      runCycles++;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("run_cycles", 64'(runCycles), 64'(expLatency(b)));
    checkOutput("done_busy", {done, busy}, 2'b10);
    checkOutput("product", product, 64'(expProd));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_idle", {product, busy, done}, '0);
    end

    applyStimulus(13, 11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("done_hold", {done, product}, {1'b1, 8'h8F});
    end

    applyStimulus(15, 15, 1'b0);
    applyStimulus(0, 9, 1'b0);

    // Reset during the second RUN cycle discards the partial product.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 4'd7;
    multiplier   = 4'd6;
    @(negedge clk);
    start = 1'b0;
    checkOutput("run_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun_reset", {product, busy, done}, '0);
    @(negedge clk);
    checkOutput("midrun_reset_idle", {product, busy, done}, '0);
    applyStimulus(7, 6, 1'b0);

    applyStimulus(11, 13, 1'b1);
    applyStimulus(3, 1, 1'b0);
    applyStimulus(5, 0, 1'b0);
    applyStimulus(9, 8, 1'b0);
    applyStimulus(15, 0, 1'b1);

    for (int i = 0; i < 25; i++)
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
